bus_scan_mux: RTL
=================

BUS_SCAN_MUX -- requirements
Module: bus_scan_mux

Interface
Parameters (one per line: name, default, meaning)
REQ-001 SHALL provide parameter WIDTH, default 16, bit width of each channel and of out_bus.
REQ-002 SHALL provide parameter CHANNELS, default 16, number of input channels, legal range 2..2^SELW.
REQ-003 SHALL provide parameter SELW, default 4, width of sel and out_sel.

Ports (one per line: name, direction, width, meaning; clock and reset first)
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_bus, input, CHANNELS*WIDTH, flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port sel, input, SELW, channel index used in direct mode.
REQ-008 SHALL have port mode, input, 1, 0 = direct single read, 1 = scan of all channels.
REQ-009 SHALL have port start, input, 1, single-cycle request to begin an operation.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts out_bus this cycle.
REQ-011 SHALL have port out_bus, output reg, WIDTH, captured channel data.
REQ-012 SHALL have port out_sel, output reg, SELW, index of the channel held in out_bus.
REQ-013 SHALL have port out_valid, output reg, 1, out_bus and out_sel are valid.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output reg, 1, one-cycle pulse when an operation completes.
REQ-016 SHALL have port sel_err, output reg, 1, sticky flag: a direct read used sel >= CHANNELS.

Function
REQ-017 SHALL implement an FSM with states IDLE and XFER; busy = (state == XFER).
REQ-018 In IDLE, start=1 SHALL latch mode and go to XFER at the next edge, with out_valid=1 from that edge (latency 1 cycle).
REQ-019 The capture edge SHALL load out_bus from in_bus at that edge: channel sel in direct mode, channel 0 in scan mode; out_sel SHALL be loaded with the same index.
REQ-020 A direct read with sel >= CHANNELS SHALL load out_bus = 0 and out_sel = sel, and SHALL set sel_err.
REQ-021 A transfer SHALL occur on an edge where out_valid && out_ready; while out_valid=1 and out_ready=0, out_bus and out_sel SHALL hold and SHALL NOT track in_bus.
REQ-022 In direct mode, a transfer SHALL clear out_valid, return the FSM to IDLE and pulse done for the following cycle.
REQ-023 In scan mode, a transfer of channel k < CHANNELS-1 SHALL load channel k+1 on the same edge with out_valid held at 1 (one word per cycle when out_ready stays high).
REQ-024 In scan mode, a transfer of channel CHANNELS-1 SHALL clear out_valid, return to IDLE and pulse done; the scan index SHALL NOT wrap.
REQ-025 start, sel and mode SHALL be ignored while busy=1.
REQ-026 start in the cycle done is high SHALL be accepted, because the FSM is already in IDLE.
REQ-027 sel_err SHALL clear only on reset.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, out_bus=0, out_sel=0, out_valid=0, done=0, sel_err=0 and scan index=0, including in the middle of a scan.
REQ-029 After reset deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-030 Direct read: channel 5 = 16'hA5A5, sel=5, mode=0, start pulse, out_ready=1 -> next cycle out_valid=1, out_bus=16'hA5A5, out_sel=5; following cycle done=1, busy=0.
REQ-031 Back-pressure: as REQ-030 with out_ready=0 for 4 cycles while channel 5 changes to 16'h1234 -> out_bus stays 16'hA5A5 until out_ready=1; exactly one transfer occurs.
REQ-032 Full scan: channel k = k*16'h0101, mode=1, out_ready=1 -> 16 consecutive transfers with out_sel 0..15 and matching data, then one done pulse, no wrap.
REQ-033 Scan with stalls: out_ready toggles randomly -> same ordered sequence as REQ-032, no channel dropped or duplicated.
REQ-034 Error select: CHANNELS=12, sel=13, direct read -> out_bus=0, out_sel=13, sel_err=1, and sel_err stays 1 through a later legal read.
REQ-035 Reset mid-scan: assert reset asynchronously after 7 transfers -> all outputs reach reset values before the next clk edge; a new scan then starts again at channel 0.

Source files
------------

// File: rtl/bus_scan_mux_if.sv
// Handshake and data bundle for bus_scan_mux.
// The consumer-side master drives the request; the mux is the slave.
interface bus_scan_mux_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 16,
   parameter int SELW     = 4
);
   logic [CHANNELS*WIDTH-1:0] in_bus;
   logic [SELW-1:0]           sel;
   logic                      mode;
   logic                      start;
   logic                      out_ready;
   logic [WIDTH-1:0]          out_bus;
   logic [SELW-1:0]           out_sel;
   logic                      out_valid;
   logic                      busy;
   logic                      done;
   logic                      sel_err;

   modport master (
      output in_bus, sel, mode, start, out_ready,
      input  out_bus, out_sel, out_valid, busy, done, sel_err
   );

   modport slave (
      input  in_bus, sel, mode, start, out_ready,
      output out_bus, out_sel, out_valid, busy, done, sel_err
   );
endinterface

// File: rtl/bus_scan_mux.sv
// Channel mux with single direct read or ordered scan of all channels.
// Output word is held under back-pressure and released on valid/ready.
module bus_scan_mux #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 16,
   parameter int SELW     = 4
) (
   input logic clk,
   input logic reset,
   bus_scan_mux_if.slave bus
);
   typedef enum logic {IDLE, XFER} state_t;

   localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

   state_t           state;
   state_t           nextState;
   logic             scanMode;
   logic [SELW-1:0]  scanIdx;
   logic [WIDTH-1:0] outBus;
   logic [SELW-1:0]  outSel;
   logic             outValid;
   logic             doneQ;
   logic             selErr;

   logic             load;
   logic             finish;
   logic             badSel;
   logic [SELW-1:0]  loadIdx;
   logic [WIDTH-1:0] loadData;

   // Next state, capture request and completion decode
   always_comb begin
      nextState = state;
      load      = 1'b0;
      finish    = 1'b0;
      badSel    = 1'b0;
      loadIdx   = scanIdx + SELW'(1);
      case (state)
         IDLE: begin
            if (bus.start) begin
               nextState = XFER;
               load      = 1'b1;
               loadIdx   = bus.mode ? '0 : bus.sel;
               badSel    = !bus.mode &&
                           (32'(bus.sel) >= 32'(CHANNELS));
            end
         end
         XFER: begin
            if (outValid && bus.out_ready) begin
               if (scanMode && scanIdx != LAST) begin
                  load = 1'b1;
               end else begin
                  nextState = IDLE;
                  finish    = 1'b1;
               end
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Channel select; indices past the last channel read as zero
   always_comb begin
      loadData = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (loadIdx == SELW'(k)) begin
            loadData = bus.in_bus[k*WIDTH +: WIDTH];
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Output word, scan index, done pulse and sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outBus   <= '0;
         outSel   <= '0;
         outValid <= 1'b0;
         doneQ    <= 1'b0;
         selErr   <= 1'b0;
         scanMode <= 1'b0;
         scanIdx  <= '0;
      end else begin
         doneQ <= finish;
         if (load) begin
            outBus   <= loadData;
            outSel   <= loadIdx;
            outValid <= 1'b1;
            scanIdx  <= loadIdx;
         end else if (finish) begin
            outValid <= 1'b0;
         end
         if (state == IDLE && bus.start) scanMode <= bus.mode;
         if (badSel) selErr <= 1'b1;
      end
   end

   assign bus.out_bus   = outBus;
   assign bus.out_sel   = outSel;
   assign bus.out_valid = outValid;
   assign bus.done      = doneQ;
   assign bus.sel_err   = selErr;
   assign bus.busy      = (state == XFER);
endmodule
